jtframe_vidgen: RTL

Video timing generator that produces the pixel/line counters and the active-high-visible blanking signals `LHBL`/`LVBL` plus sync pulses consumed by colour-mixing and blanking-delay stages. It sits at the head of every core's video path. One `pxl_cen` pulse advances one pixel. All outputs are registered and mutually aligned, so downstream stages can delay them as one bundle.

---
 rtl/jtframe_vidgen_if.sv | 26 ++
 rtl/jtframe_vidgen.sv | 91 +++++++++
 2 files changed

// File: rtl/jtframe_vidgen_if.sv
// Video timing bundle: pixel enable in, counters and aligned blanking/sync flags out.
interface jtframe_vidgen_if #(
    parameter int HW = 9,
    parameter int VW = 9
);
    logic          pxl_cen;
    logic [HW-1:0] H;
    logic [VW-1:0] V;
    logic          Hinit;
    logic          Vinit;
    logic          LHBL;
    logic          LVBL;
    logic          HS;
    logic          VS;
    logic [7:0]    frame;

    modport master (
        input  pxl_cen,
        output H, V, Hinit, Vinit, LHBL, LVBL, HS, VS, frame
    );

    modport slave (
        output pxl_cen,
        input  H, V, Hinit, Vinit, LHBL, LVBL, HS, VS, frame
    );
endinterface

// File: rtl/jtframe_vidgen.sv
// Pixel/line counter chain with registered window decodes, so every flag
// and counter leaves on the same edge and can be delayed as one bundle.
module jtframe_vidgen #(
    parameter int HW       = 9,
    parameter int VW       = 9,
    parameter int HCNT_END = 383,
    parameter int HB_START = 256,
    parameter int HB_END   = 0,
    parameter int HS_START = 296,
    parameter int HS_END   = 328,
    parameter int VCNT_END = 263,
    parameter int VB_START = 224,
    parameter int VB_END   = 0,
    parameter int VS_START = 240,
    parameter int VS_END   = 243
) (
    input  logic             clk,
    input  logic             rst,
    jtframe_vidgen_if.master vid
);
    localparam logic [HW-1:0] HCNT_END_C = HW'(HCNT_END);
    localparam logic [HW-1:0] HB_START_C = HW'(HB_START);
    localparam logic [HW-1:0] HB_END_C   = HW'(HB_END);
    localparam logic [HW-1:0] HS_START_C = HW'(HS_START);
    localparam logic [HW-1:0] HS_END_C   = HW'(HS_END);
    localparam logic [VW-1:0] VCNT_END_C = VW'(VCNT_END);
    localparam logic [VW-1:0] VB_START_C = VW'(VB_START);
    localparam logic [VW-1:0] VB_END_C   = VW'(VB_END);
    localparam logic [VW-1:0] VS_START_C = VW'(VS_START);
    localparam logic [VW-1:0] VS_END_C   = VW'(VS_END);

    // Visible window [lo, hi) is the complement of blanking given lo < hi,
    // and a zero lo naturally drops the "below lo" blanking term.
    function automatic logic hwin(input logic [HW-1:0] x, input logic [HW-1:0] lo,
                                  input logic [HW-1:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

    function automatic logic vwin(input logic [VW-1:0] x, input logic [VW-1:0] lo,
                                  input logic [VW-1:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

    logic [HW-1:0] h_q, hn_d;
    logic [VW-1:0] v_q, vn_d;
    logic [7:0]    frame_q;
    logic          lhbl_q, lvbl_q, hs_q, vs_q, hinit_q, vinit_q;
    logic          top_d;

    always_comb begin
        hn_d  = (h_q == HCNT_END_C) ? '0 : h_q + HW'(1);
        vn_d  = v_q;
        if (h_q == HCNT_END_C)
            vn_d = (v_q == VCNT_END_C) ? '0 : v_q + VW'(1);
        top_d = (hn_d == '0) && (vn_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
            lhbl_q  <= 1'b0;
            lvbl_q  <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            hinit_q <= 1'b0;
            vinit_q <= 1'b0;
        end else if (vid.pxl_cen) begin
            h_q     <= hn_d;
            v_q     <= vn_d;
            lhbl_q  <= hwin(hn_d, HB_END_C, HB_START_C);
            lvbl_q  <= vwin(vn_d, VB_END_C, VB_START_C);
            hs_q    <= hwin(hn_d, HS_START_C, HS_END_C);
            vs_q    <= vwin(vn_d, VS_START_C, VS_END_C);
            hinit_q <= (hn_d == '0);
            vinit_q <= top_d;
            if (top_d) frame_q <= frame_q + 8'd1;
        end
    end

    assign vid.H     = h_q;
    assign vid.V     = v_q;
    assign vid.frame = frame_q;
    assign vid.LHBL  = lhbl_q;
    assign vid.LVBL  = lvbl_q;
    assign vid.HS    = hs_q;
    assign vid.VS    = vs_q;
    assign vid.Hinit = hinit_q;
    assign vid.Vinit = vinit_q;
endmodule
